// File: rtl/pc_sp_unit_pkg.sv
// Shared types and constants for the PC/SP unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_sp_unit_pkg;

  `include "symbols.vh"

  localparam int unsigned DATA_W = 8;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/pc_sp_unit_stack_counter.sv
// Stack pointer register with optional saturating guard (macro STACK_GUARD_EN).
// Latency: value updates on the edge that samples inc/dec.
// Backpressure: none; inc/dec are one-shot requests, dec wins if both are set.
module stack_counter
  import pc_sp_unit_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  inc,
  input  logic  dec,
  output word_t value,
  output logic  ovf,
  output logic  udf
);

  word_t value_d, value_q;

`ifdef STACK_GUARD_EN
  logic ovf_d, ovf_q;
  logic udf_d, udf_q;

  // Next pointer: saturate at the ends and latch the sticky fault flags.
  always_comb begin
    value_d = value_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (dec) begin
      if (value_q == 8'h00) ovf_d = 1'b1;
      else                  value_d = value_q - 8'd1;
    end else if (inc) begin
      if (value_q == 8'hFF) udf_d = 1'b1;
      else                  value_d = value_q + 8'd1;
    end
  end

  // Pointer and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= SP_RESET;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`else
  // Next pointer: plain modulo-256 up/down count.
  always_comb begin
    value_d = value_q;
    if (dec)      value_d = value_q - 8'd1;
    else if (inc) value_d = value_q + 8'd1;
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= SP_RESET;
    else     value_q <= value_d;
  end

  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

  assign value = value_q;

endmodule

// File: rtl/symbols.vh
// Shared sequencer state codes and reset constants; included inside pc_sp_unit_pkg.
// Only the package includes this file, so every consumer sees a single definition.
// Codes are 8-bit so they compare directly against the sequencer's state bus.
`ifndef SYMBOLS_VH
`define SYMBOLS_VH

localparam logic [7:0] STATE_NEXT      = 8'h00;
localparam logic [7:0] STATE_FETCH_PC  = 8'h01;
localparam logic [7:0] STATE_FETCH_SP  = 8'h02;
localparam logic [7:0] STATE_STACK_REG = 8'h03;
localparam logic [7:0] STATE_INC_SP    = 8'h04;
localparam logic [7:0] STATE_SET_REG   = 8'h05;
localparam logic [7:0] STATE_JUMP      = 8'h06;
localparam logic [7:0] STATE_STORE_PC  = 8'h07;
localparam logic [7:0] STATE_TMP_JUMP  = 8'h08;
localparam logic [7:0] STATE_RET       = 8'h09;
localparam logic [7:0] STATE_HALT      = 8'h0A;

localparam logic [7:0] PC_RESET = 8'h00;
localparam logic [7:0] SP_RESET = 8'hFF;

`endif

// File: rtl/pc_sp_unit.sv
// Program counter, stack pointer and memory address register driven by sequencer state.
// Latency: one action per rising edge on the sampled state; mem_we pulses the cycle after a push.
// Backpressure: none; optional stack guard selected by macro STACK_GUARD_EN.
module pc_sp_unit
  import pc_sp_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] state,
  input  logic [7:0] bus_in,
  output logic [7:0] addr,
  output logic [7:0] pc,
  output logic [7:0] sp,
  output logic [7:0] pc_data,
  output logic       mem_we,
  output logic       halted,
  output logic       stack_ovf,
  output logic       stack_udf
);

  word_t pc_d, pc_q;
  word_t addr_d, addr_q;
  word_t tmp_d, tmp_q;
  word_t pc_data_d, pc_data_q;
  logic  mem_we_d, mem_we_q;
  logic  halted_d, halted_q;
  logic  sp_inc, sp_dec;
  word_t sp_val;

  // Decode the sampled state into next register values; halted ignores everything.
  always_comb begin
    pc_d      = pc_q;
    addr_d    = addr_q;
    tmp_d     = tmp_q;
    pc_data_d = pc_data_q;
    mem_we_d  = 1'b0;
    halted_d  = halted_q;
    sp_inc    = 1'b0;
    sp_dec    = 1'b0;
    if (!halted_q) begin
      case (state)
        STATE_FETCH_PC: begin
          addr_d = pc_q;
          pc_d   = pc_q + 8'd1;
        end
        STATE_FETCH_SP:  addr_d = sp_val;
        STATE_STACK_REG: begin
          sp_dec   = 1'b1;
          mem_we_d = 1'b1;
        end
        STATE_INC_SP:    sp_inc = 1'b1;
        STATE_SET_REG:   tmp_d  = bus_in;
        STATE_JUMP:      pc_d   = bus_in;
        STATE_STORE_PC: begin
          addr_d    = sp_val;
          pc_data_d = pc_q;
          sp_dec    = 1'b1;
          mem_we_d  = 1'b1;
        end
        STATE_TMP_JUMP:  pc_d     = tmp_q;
        STATE_RET:       pc_d     = bus_in;
        STATE_HALT:      halted_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Architectural registers; reset clears any half-finished sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= PC_RESET;
      addr_q    <= 8'h00;
      tmp_q     <= 8'h00;
      pc_data_q <= 8'h00;
      mem_we_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      tmp_q     <= tmp_d;
      pc_data_q <= pc_data_d;
      mem_we_q  <= mem_we_d;
      halted_q  <= halted_d;
    end
  end

  stack_counter u_stack (
    .clk   (clk),
    .rst   (reset),
    .inc   (sp_inc),
    .dec   (sp_dec),
    .value (sp_val),
    .ovf   (stack_ovf),
    .udf   (stack_udf)
  );

  assign pc      = pc_q;
  assign addr    = addr_q;
  assign sp      = sp_val;
  assign pc_data = pc_data_q;
  assign mem_we  = mem_we_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_pc_sp_unit.sv
// Directed self-checking bench for pc_sp_unit (default build, or guard build with STACK_GUARD_EN).
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
// Each task checks its own scenario against hand-computed values.
module tb_pc_sp_unit;
  import pc_sp_unit_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] state;
  logic [7:0] bus_in;
  logic [7:0] addr, pc, sp, pc_data;
  logic       mem_we, halted, stack_ovf, stack_udf;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pc_sp_unit dut (
    .clk       (clk),
    .reset     (reset),
    .state     (state),
    .bus_in    (bus_in),
    .addr      (addr),
    .pc        (pc),
    .sp        (sp),
    .pc_data   (pc_data),
    .mem_we    (mem_we),
    .halted    (halted),
    .stack_ovf (stack_ovf),
    .stack_udf (stack_udf)
  );

  task automatic step(input logic [7:0] s, input logic [7:0] b);
    @(negedge clk);
    state  = s;
    bus_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    state = STATE_NEXT;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; state = STATE_FETCH_PC; bus_in = 8'hAA;
    #12;
    n_total++; if (pc !== 8'h00)      $display("FAIL rst_pc got %h want 00", pc);      else n_pass++;
    n_total++; if (sp !== 8'hFF)      $display("FAIL rst_sp got %h want FF", sp);      else n_pass++;
    n_total++; if (addr !== 8'h00)    $display("FAIL rst_addr got %h want 00", addr);  else n_pass++;
    n_total++; if (pc_data !== 8'h00) $display("FAIL rst_pc_data got %h want 00", pc_data); else n_pass++;
    n_total++; if (mem_we !== 1'b0)   $display("FAIL rst_mem_we got %b want 0", mem_we); else n_pass++;
    n_total++; if (halted !== 1'b0)   $display("FAIL rst_halted got %b want 0", halted); else n_pass++;
    n_total++; if (stack_ovf !== 1'b0) $display("FAIL rst_ovf got %b want 0", stack_ovf); else n_pass++;
    n_total++; if (stack_udf !== 1'b0) $display("FAIL rst_udf got %b want 0", stack_udf); else n_pass++;
  endtask

  task automatic test_fetch();
    do_reset();
    step(STATE_FETCH_PC, 8'h00);
    n_total++; if (pc !== 8'h01) $display("FAIL first_edge_pc got %h want 01", pc); else n_pass++;
    step(STATE_FETCH_PC, 8'h00);
    step(STATE_FETCH_PC, 8'h00);
    n_total++; if (addr !== 8'h02) $display("FAIL fetch3_addr got %h want 02", addr); else n_pass++;
    n_total++; if (pc !== 8'h03)   $display("FAIL fetch3_pc got %h want 03", pc);     else n_pass++;
    step(STATE_NEXT, 8'h77);
    n_total++; if (pc !== 8'h03 || addr !== 8'h02) $display("FAIL next_hold got pc=%h addr=%h want 03/02", pc, addr); else n_pass++;
  endtask

  task automatic test_pc_wrap();
    step(STATE_JUMP, 8'hFF);
    n_total++; if (pc !== 8'hFF) $display("FAIL jump_pc got %h want FF", pc); else n_pass++;
    step(STATE_FETCH_PC, 8'h00);
    n_total++; if (addr !== 8'hFF) $display("FAIL wrap_addr got %h want FF", addr); else n_pass++;
    n_total++; if (pc !== 8'h00)   $display("FAIL wrap_pc got %h want 00", pc);     else n_pass++;
  endtask

  task automatic test_push_pop();
    do_reset();
    step(STATE_FETCH_SP, 8'h00);
    n_total++; if (addr !== 8'hFF) $display("FAIL push_addr got %h want FF", addr); else n_pass++;
    step(STATE_STACK_REG, 8'h00);
    n_total++; if (sp !== 8'hFE)    $display("FAIL push_sp got %h want FE", sp);       else n_pass++;
    n_total++; if (mem_we !== 1'b1) $display("FAIL push_we got %b want 1", mem_we);    else n_pass++;
    step(STATE_INC_SP, 8'h00);
    n_total++; if (mem_we !== 1'b0) $display("FAIL push_we_pulse got %b want 0", mem_we); else n_pass++;
    step(STATE_FETCH_SP, 8'h00);
    n_total++; if (sp !== 8'hFF)   $display("FAIL pop_sp got %h want FF", sp);     else n_pass++;
    n_total++; if (addr !== 8'hFF) $display("FAIL pop_addr got %h want FF", addr); else n_pass++;
  endtask

  task automatic test_call_ret();
    do_reset();
    step(STATE_JUMP, 8'h10);
    step(STATE_FETCH_PC, 8'h00);
    step(STATE_SET_REG, 8'h40);
    step(STATE_STORE_PC, 8'h00);
    n_total++; if (pc_data !== 8'h11) $display("FAIL call_pc_data got %h want 11", pc_data); else n_pass++;
    n_total++; if (sp !== 8'hFE)      $display("FAIL call_sp got %h want FE", sp);           else n_pass++;
    n_total++; if (addr !== 8'hFF)    $display("FAIL call_addr got %h want FF", addr);       else n_pass++;
    n_total++; if (mem_we !== 1'b1)   $display("FAIL call_we got %b want 1", mem_we);        else n_pass++;
    step(STATE_TMP_JUMP, 8'h00);
    n_total++; if (pc !== 8'h40)    $display("FAIL call_pc got %h want 40", pc);      else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL call_we_low got %b want 0", mem_we); else n_pass++;
    step(STATE_INC_SP, 8'h00);
    step(STATE_FETCH_SP, 8'h00);
    step(STATE_RET, 8'h11);
    n_total++; if (pc !== 8'h11) $display("FAIL ret_pc got %h want 11", pc); else n_pass++;
    n_total++; if (sp !== 8'hFF) $display("FAIL ret_sp got %h want FF", sp); else n_pass++;
  endtask

  task automatic test_guard();
    do_reset();
    for (int i = 0; i < 255; i++) step(STATE_STACK_REG, 8'h00);
    n_total++; if (sp !== 8'h00) $display("FAIL drain_sp got %h want 00", sp); else n_pass++;
    step(STATE_STACK_REG, 8'h00);
`ifdef STACK_GUARD_EN
    n_total++; if (sp !== 8'h00)       $display("FAIL ovf_sp got %h want 00", sp);        else n_pass++;
    n_total++; if (stack_ovf !== 1'b1) $display("FAIL ovf_flag got %b want 1", stack_ovf); else n_pass++;
`else
    n_total++; if (sp !== 8'hFF)       $display("FAIL ovf_sp got %h want FF", sp);        else n_pass++;
    n_total++; if (stack_ovf !== 1'b0) $display("FAIL ovf_flag got %b want 0", stack_ovf); else n_pass++;
`endif
    n_total++; if (mem_we !== 1'b1) $display("FAIL ovf_we got %b want 1", mem_we); else n_pass++;
    do_reset();
    step(STATE_INC_SP, 8'h00);
`ifdef STACK_GUARD_EN
    n_total++; if (sp !== 8'hFF)       $display("FAIL udf_sp got %h want FF", sp);        else n_pass++;
    n_total++; if (stack_udf !== 1'b1) $display("FAIL udf_flag got %b want 1", stack_udf); else n_pass++;
    step(STATE_FETCH_SP, 8'h00);
    n_total++; if (stack_udf !== 1'b1) $display("FAIL udf_sticky got %b want 1", stack_udf); else n_pass++;
`else
    n_total++; if (sp !== 8'h00)       $display("FAIL udf_sp got %h want 00", sp);        else n_pass++;
    n_total++; if (stack_udf !== 1'b0) $display("FAIL udf_flag got %b want 0", stack_udf); else n_pass++;
`endif
  endtask

  task automatic test_halt();
    do_reset();
    step(STATE_JUMP, 8'h20);
    step(STATE_HALT, 8'h00);
    n_total++; if (halted !== 1'b1) $display("FAIL halt_flag got %b want 1", halted); else n_pass++;
    step(STATE_FETCH_PC, 8'h00);
    step(STATE_JUMP, 8'h55);
    n_total++; if (pc !== 8'h20)   $display("FAIL halt_pc got %h want 20", pc);     else n_pass++;
    n_total++; if (addr !== 8'h00) $display("FAIL halt_addr got %h want 00", addr); else n_pass++;
    step(STATE_STACK_REG, 8'h00);
    n_total++; if (sp !== 8'hFF)    $display("FAIL halt_sp got %h want FF", sp);     else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL halt_we got %b want 0", mem_we);  else n_pass++;
    n_total++; if (halted !== 1'b1) $display("FAIL halt_sticky got %b want 1", halted); else n_pass++;
  endtask

  task automatic test_reset_mid_call();
    do_reset();
    step(STATE_JUMP, 8'h10);
    step(STATE_FETCH_PC, 8'h00);
    step(STATE_SET_REG, 8'h40);
    step(STATE_STORE_PC, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    state = STATE_TMP_JUMP;
    #1;
    n_total++; if (pc !== 8'h00 || sp !== 8'hFF || addr !== 8'h00)
      $display("FAIL midrst_regs got pc=%h sp=%h addr=%h want 00/FF/00", pc, sp, addr); else n_pass++;
    n_total++; if (pc_data !== 8'h00 || mem_we !== 1'b0 || halted !== 1'b0)
      $display("FAIL midrst_misc got pc_data=%h we=%b halted=%b want 00/0/0", pc_data, mem_we, halted); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (pc !== 8'h00) $display("FAIL midrst_hold_pc got %h want 00", pc); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    step(STATE_TMP_JUMP, 8'h00);
    n_total++; if (pc !== 8'h00) $display("FAIL midrst_tmp got %h want 00", pc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_pc_wrap();
    test_push_pop();
    test_call_ret();
    test_guard();
    test_halt();
    test_reset_mid_call();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
